// File: rtl/if_pkg.sv
// Shared fetch-stage types and constants.
// Holds the FSM encoding, bus widths, the reset PC and the PC increment helper.
package if_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = 64'h0;
    localparam logic [ADDR_W-1:0] PC_INC   = 64'd4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        KILL,
        HOLD
    } fetch_state_t;

    // Sequential PC; wraps modulo 2^ADDR_W by construction.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bundle: instruction-memory req/ack, EX redirect, ID stall and IF/ID fields.
// The master side is the fetch sequencer; the slave side is the memory/pipeline environment.
interface if_fetch_ctrl_if;
    import if_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               stall;
    logic               if_valid;
    logic [ADDR_W-1:0]  if_pc;
    logic [ADDR_W-1:0]  if_pcplus4;
    logic [INSTR_W-1:0] if_instr;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_pcplus4, if_instr,
        input  imem_ack, imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_pcplus4, if_instr,
        output imem_ack, imem_rdata, redirect, redirect_pc, stall
    );

endinterface

// File: rtl/if_hold_buf.sv
// One-entry skid buffer for a fetched (instr, pc) pair; data visible the cycle after load.
// No backpressure of its own: the owner only loads it when empty, clear wins over load.
module if_hold_buf
    import if_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               clear_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic               valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o
);

    logic               valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            instr_q <= instr_i;
            pc_q    <= pc_i;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF fetch sequencer: one outstanding imem request, IF/ID updated one cycle after ack.
// ID stall parks at most one fetched instruction in the hold buffer and pauses requests.
module if_fetch_ctrl
    import if_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = if_pkg::RESET_PC
) (
    input logic              clk,
    input logic              reset,
    if_fetch_ctrl_if.master  fio
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  tgt_q, tgt_d;
    logic               if_valid_q, if_valid_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [ADDR_W-1:0]  if_pcplus4_q, if_pcplus4_d;
    logic [INSTR_W-1:0] if_instr_q, if_instr_d;

    logic               buf_load, buf_clear, buf_valid;
    logic [INSTR_W-1:0] buf_instr;
    logic [ADDR_W-1:0]  buf_pc;

    logic [ADDR_W-1:0]  rpc;
    logic               slot_free;

    assign rpc       = fio.redirect_pc & ALIGN_MASK;
    assign slot_free = !if_valid_q || !fio.stall;

    if_hold_buf u_hold_buf (
        .clk     (clk),
        .rst     (reset),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .instr_i (fio.imem_rdata),
        .pc_i    (pc_q),
        .valid_o (buf_valid),
        .instr_o (buf_instr),
        .pc_o    (buf_pc)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        tgt_d        = tgt_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_pcplus4_d = if_pcplus4_q;
        if_instr_d   = if_instr_q;
        buf_load     = 1'b0;
        buf_clear    = 1'b0;

        // ID consumption and flush both empty the slot; refills below override.
        if ((if_valid_q && !fio.stall) || fio.redirect) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (fio.redirect) pc_d = rpc;
            end
            REQ: begin
                if (fio.imem_ack) begin
                    if (fio.redirect) begin
                        pc_d = rpc;
                    end else if (slot_free) begin
                        if_valid_d   = 1'b1;
                        if_pc_d      = pc_q;
                        if_pcplus4_d = pc_inc(pc_q);
                        if_instr_d   = fio.imem_rdata;
                        pc_d         = pc_inc(pc_q);
                    end else begin
                        buf_load = 1'b1;
                        pc_d     = pc_inc(pc_q);
                        state_d  = HOLD;
                    end
                end else if (fio.redirect) begin
                    // Address must stay put until the in-flight fetch is acked.
                    tgt_d   = rpc;
                    state_d = KILL;
                end
            end
            KILL: begin
                if (fio.imem_ack) begin
                    pc_d    = fio.redirect ? rpc : tgt_q;
                    state_d = REQ;
                end else if (fio.redirect) begin
                    tgt_d = rpc;
                end
            end
            HOLD: begin
                if (fio.redirect) begin
                    buf_clear = 1'b1;
                    pc_d      = rpc;
                    state_d   = REQ;
                end else if (!fio.stall && buf_valid) begin
                    if_valid_d   = 1'b1;
                    if_pc_d      = buf_pc;
                    if_pcplus4_d = pc_inc(buf_pc);
                    if_instr_d   = buf_instr;
                    buf_clear    = 1'b1;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            tgt_q        <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_pcplus4_q <= '0;
            if_instr_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            tgt_q        <= tgt_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_pcplus4_q <= if_pcplus4_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign fio.imem_req   = (state_q == REQ) || (state_q == KILL);
    assign fio.imem_addr  = pc_q;
    assign fio.if_valid   = if_valid_q;
    assign fio.if_pc      = if_pc_q;
    assign fio.if_pcplus4 = if_pcplus4_q;
    assign fio.if_instr   = if_instr_q;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl with a program-order reference model and a
// variable-latency memory; a second instance exercises PC wrap-around.
module tb_if_fetch_ctrl;
    import if_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    if_fetch_ctrl_if fio();
    if_fetch_ctrl_if fio2();

    if_fetch_ctrl dut (.clk(clk), .reset(reset), .fio(fio));
    if_fetch_ctrl #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (.clk(clk), .reset(reset), .fio(fio2));

    int n_cmp = 0;
    int n_bad = 0;

    // Memory model state
    int   lat = 0;
    int   cnt = 0;
    logic force_ack = 1'b0;

    function automatic logic [31:0] mem_f(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (fio.imem_req) begin
            fio.imem_ack = (cnt >= lat);
            cnt = fio.imem_ack ? 0 : cnt + 1;
        end else begin
            fio.imem_ack = force_ack;
            cnt = 0;
        end
        fio.imem_rdata  = fio.imem_ack ? mem_f(fio.imem_addr) : 32'hBAD0_BAD0;
        fio2.imem_ack   = 1'b1;
        fio2.imem_rdata = mem_f(fio2.imem_addr);
    endtask

    // Reference model: expected next fetch address, expected next instruction
    // handed to ID, and whether the in-flight fetch has been superseded.
    logic [63:0] exp_fetch, exp_deliver, prev_addr;
    logic        killed, prev_waiting, prev_redirect, prev_hold;
    logic [63:0] prev_pc, prev_pc4;
    logic [31:0] prev_instr;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_req", fio.imem_req, 0);
            chk("rst_addr", fio.imem_addr, 0);
            chk("rst_valid", fio.if_valid, 0);
            chk("rst_pc", fio.if_pc, 0);
            chk("rst_pc4", fio.if_pcplus4, 0);
            chk("rst_instr", fio.if_instr, 0);
            exp_fetch = 64'h0;
            exp_deliver = 64'h0;
            killed = 0;
            prev_waiting = 0;
            prev_redirect = 0;
            prev_hold = 0;
        end else begin
            if (prev_waiting) begin
                chk("addr_hold_req", fio.imem_req, 1);
                chk("addr_hold", fio.imem_addr, prev_addr);
            end else if (fio.imem_req) begin
                chk("fetch_addr", fio.imem_addr, exp_fetch);
            end
            if (prev_redirect) chk("flush_valid", fio.if_valid, 0);
            if (prev_hold) begin
                chk("stall_valid", fio.if_valid, 1);
                chk("stall_pc", fio.if_pc, prev_pc);
                chk("stall_pc4", fio.if_pcplus4, prev_pc4);
                chk("stall_instr", fio.if_instr, prev_instr);
            end
            if (fio.if_valid) begin
                chk("pcplus4", fio.if_pcplus4, fio.if_pc + 64'd4);
                chk("instr_data", fio.if_instr, mem_f(fio.if_pc));
                if (!fio.stall) begin
                    chk("deliver_order", fio.if_pc, exp_deliver);
                    exp_deliver = exp_deliver + 64'd4;
                end
            end
            if (fio.redirect) begin
                exp_fetch   = fio.redirect_pc & ~64'h3;
                exp_deliver = fio.redirect_pc & ~64'h3;
            end else if (fio.imem_req && fio.imem_ack && !killed) begin
                exp_fetch = fio.imem_addr + 64'd4;
            end
            killed        = fio.imem_req && !fio.imem_ack && (killed || fio.redirect);
            prev_waiting  = fio.imem_req && !fio.imem_ack;
            prev_addr     = fio.imem_addr;
            prev_redirect = fio.redirect;
            prev_hold     = fio.if_valid && fio.stall && !fio.redirect;
            prev_pc       = fio.if_pc;
            prev_pc4      = fio.if_pcplus4;
            prev_instr    = fio.if_instr;
        end
    end

    initial begin
        logic found;
        fio.imem_ack = 0; fio.imem_rdata = 0; fio.redirect = 0; fio.redirect_pc = 0; fio.stall = 0;
        fio2.imem_ack = 0; fio2.imem_rdata = 0; fio2.redirect = 0; fio2.redirect_pc = 0; fio2.stall = 0;

        // 1: reset, then 0-wait streaming (and 5: wrap instance alongside)
        tick(); tick();
        reset = 0;
        chk("c0_req", fio.imem_req, 0);
        tick();
        chk("c1_req", fio.imem_req, 1);
        chk("c1_addr", fio.imem_addr, 64'h0);
        chk("c1_valid", fio.if_valid, 0);
        chk("w_c1_addr", fio2.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk("c2_addr", fio.imem_addr, 64'h4);
        chk("c2_valid", fio.if_valid, 1);
        chk("c2_pc", fio.if_pc, 64'h0);
        chk("c2_pc4", fio.if_pcplus4, 64'h4);
        chk("c2_instr", fio.if_instr, 32'hC0DE_5A5A);
        chk("w_c2_addr", fio2.imem_addr, 64'h0);
        chk("w_c2_pc", fio2.if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("w_c2_pc4", fio2.if_pcplus4, 64'h0);
        chk("w_c2_instr", fio2.if_instr, 32'hC0DE_5A59);
        tick();
        chk("c3_pc", fio.if_pc, 64'h4);
        chk("w_c3_pc", fio2.if_pc, 64'h0);
        tick(); tick();
        chk("c5_addr", fio.imem_addr, 64'h10);
        chk("c5_pc", fio.if_pc, 64'hC);

        // 2: stall for 3 cycles
        fio.stall = 1;
        tick();
        chk("s1_req", fio.imem_req, 0);
        chk("s1_pc", fio.if_pc, 64'hC);
        tick(); tick();
        chk("s3_req", fio.imem_req, 0);
        fio.stall = 0;
        tick();
        chk("rel_pc", fio.if_pc, 64'h10);
        chk("rel_addr", fio.imem_addr, 64'h14);
        chk("rel_req", fio.imem_req, 1);
        tick();
        chk("rel2_pc", fio.if_pc, 64'h14);

        // 3: 3-cycle memory, redirect in first wait cycle
        lat = 3;
        tick();
        chk("lat_addr", fio.imem_addr, 64'h1C);
        chk("lat_ack", fio.imem_ack, 0);
        fio.redirect = 1; fio.redirect_pc = 64'h100;
        tick();
        fio.redirect = 0;
        chk("kill_addr", fio.imem_addr, 64'h1C);
        chk("kill_valid", fio.if_valid, 0);
        tick(); tick(); tick();
        chk("tgt_addr", fio.imem_addr, 64'h100);
        chk("tgt_valid", fio.if_valid, 0);
        tick(); tick(); tick(); tick();
        chk("tgt_pc", fio.if_pc, 64'h100);
        chk("tgt_instr", fio.if_instr, 32'hC0DE_5B5A);

        // 4a: redirect with ack in the same cycle
        lat = 0;
        tick(); tick();
        chk("r4_pc", fio.if_pc, 64'h104);
        chk("r4_ack", fio.imem_ack, 1);
        fio.redirect = 1; fio.redirect_pc = 64'h200;
        tick();
        fio.redirect = 0;
        chk("r4_valid", fio.if_valid, 0);
        chk("r4_addr", fio.imem_addr, 64'h200);
        tick();
        chk("r4_tpc", fio.if_pc, 64'h200);

        // 4b: redirect while in HOLD, unaligned target
        fio.stall = 1;
        tick();
        chk("h_req", fio.imem_req, 0);
        fio.redirect = 1; fio.redirect_pc = 64'h303;
        tick();
        fio.redirect = 0; fio.stall = 0;
        chk("h_valid", fio.if_valid, 0);
        chk("h_addr", fio.imem_addr, 64'h300);
        tick();
        chk("h_pc", fio.if_pc, 64'h300);
        tick();
        chk("h_pc2", fio.if_pc, 64'h304);

        // KILL with a second redirect: latest target wins
        lat = 4;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (fio.imem_req && !fio.imem_ack) found = 1;
        end
        chk("wait_gap", found, 1);
        fio.redirect = 1; fio.redirect_pc = 64'h400;
        tick();
        fio.redirect_pc = 64'h500;
        tick();
        fio.redirect = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (fio.if_valid) found = 1;
        end
        chk("wait_latest", found, 1);
        chk("latest_pc", fio.if_pc, 64'h500);

        // 6: reset during KILL, late ack afterwards
        fio.redirect = 1; fio.redirect_pc = 64'h600;
        tick();
        fio.redirect = 0;
        chk("k6_req", fio.imem_req, 1);
        #2 reset = 1;
        #1;
        chk("ar_req", fio.imem_req, 0);
        chk("ar_addr", fio.imem_addr, 64'h0);
        chk("ar_valid", fio.if_valid, 0);
        chk("ar_pc", fio.if_pc, 64'h0);
        chk("ar_instr", fio.if_instr, 0);
        force_ack = 1;
        tick(); tick();
        reset = 0;
        force_ack = 0;
        lat = 0;
        tick();
        chk("pr_addr", fio.imem_addr, 64'h0);
        chk("pr_valid", fio.if_valid, 0);
        tick();
        chk("pr_pc", fio.if_pc, 64'h0);
        chk("pr_vld2", fio.if_valid, 1);
        repeat (4) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
